seg_scan: RTL and testbench

- Display back-end for the clock/stopwatch/timer modes: consumes the 32-bit packed display word (8 nibbles, digit 7 = MSN, same format the stopwatch emits, e.g. {hr_10,hr_1,4'hb,min_10,min_1,4'hb,sec_10,sec_1}).
- Time-multiplexes it onto an 8-digit common-anode 7-segment display.
- Adds per-digit blanking, decimal points and blinking (used for time-setting cursor).
- Snapshots the word once per frame so a digit rollover never tears mid-scan.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_scan_if.sv | 23 ++
 rtl/seg_decode.sv | 31 +++
 rtl/seg_scan.sv | 112 +++++++++++
 tb/tb_seg_scan.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the 8-digit seven-segment scanner: digit count, special
// nibble codes and active-low glyphs ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned NDIG = 8;

  localparam logic [3:0] SEG_DASH  = 4'hB;
  localparam logic [3:0] SEG_BLANK = 4'hF;

  localparam logic [6:0] GLYPH_0    = 7'h40;
  localparam logic [6:0] GLYPH_1    = 7'h79;
  localparam logic [6:0] GLYPH_2    = 7'h24;
  localparam logic [6:0] GLYPH_3    = 7'h30;
  localparam logic [6:0] GLYPH_4    = 7'h19;
  localparam logic [6:0] GLYPH_5    = 7'h12;
  localparam logic [6:0] GLYPH_6    = 7'h02;
  localparam logic [6:0] GLYPH_7    = 7'h78;
  localparam logic [6:0] GLYPH_8    = 7'h00;
  localparam logic [6:0] GLYPH_9    = 7'h10;
  localparam logic [6:0] GLYPH_A    = 7'h08;
  localparam logic [6:0] GLYPH_DASH = 7'h3F;
  localparam logic [6:0] GLYPH_C    = 7'h46;
  localparam logic [6:0] GLYPH_D    = 7'h21;
  localparam logic [6:0] GLYPH_E    = 7'h06;
  localparam logic [6:0] GLYPH_OFF  = 7'h7F;

endpackage

// File: rtl/seg_scan_if.sv
// Display word, per-digit masks and the multiplexed anode/cathode drive.
interface seg_scan_if;

  logic [31:0] disp_data;
  logic [7:0]  blank_mask;
  logic [7:0]  dp_mask;
  logic [7:0]  blink_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  modport master (
    output disp_data, blank_mask, dp_mask, blink_mask,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  disp_data, blank_mask, dp_mask, blink_mask,
    output an, seg, dp, frame_start
  );

endinterface

// File: rtl/seg_decode.sv
// Nibble code to active-low seven-segment glyph; 0xB is the separator dash.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_OFF;
    case (code)
      4'h0:      seg = GLYPH_0;
      4'h1:      seg = GLYPH_1;
      4'h2:      seg = GLYPH_2;
      4'h3:      seg = GLYPH_3;
      4'h4:      seg = GLYPH_4;
      4'h5:      seg = GLYPH_5;
      4'h6:      seg = GLYPH_6;
      4'h7:      seg = GLYPH_7;
      4'h8:      seg = GLYPH_8;
      4'h9:      seg = GLYPH_9;
      4'hA:      seg = GLYPH_A;
      SEG_DASH:  seg = GLYPH_DASH;
      4'hC:      seg = GLYPH_C;
      4'hD:      seg = GLYPH_D;
      4'hE:      seg = GLYPH_E;
      default:   seg = GLYPH_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 8-digit common-anode driver with per-frame snapshot,
// per-digit blanking, decimal points and blinking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned GUARD        = 200,
  parameter int unsigned BLINK_FRAMES = 62
) (
  input  logic      clk,
  input  logic      reset,
  seg_scan_if.slave bus
);

  localparam int unsigned PW = $clog2(SCAN_DIV + 1);
  localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    blank_snap_q, blank_snap_d;
  logic [7:0]    dp_snap_q, dp_snap_d;
  logic [7:0]    blink_snap_q, blink_snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q;
  logic          dp_q, dp_d;
  logic          frame_start_q;

  logic          tick, wrap, guard, dark;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  assign tick   = (prescaler_q == PW'(SCAN_DIV - 1));
  assign wrap   = tick && (idx_q == 3'(NDIG - 1));
  assign guard  = (prescaler_q < PW'(GUARD));
  assign nibble = snap_q[{idx_q, 2'b00} +: 4];
  assign dark   = blank_snap_q[idx_q] | (blink_snap_q[idx_q] & ~blink_on_q);

  seg_decode u_decode (
    .code (nibble),
    .seg  (glyph)
  );

  always_comb begin
    prescaler_d  = tick ? '0 : prescaler_q + PW'(1);
    idx_d        = tick ? idx_q + 3'd1 : idx_q;
    snap_d       = snap_q;
    blank_snap_d = blank_snap_q;
    dp_snap_d    = dp_snap_q;
    blink_snap_d = blink_snap_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    // Everything shown during a frame is latched together so nothing tears mid-scan.
    if (wrap) begin
      snap_d       = bus.disp_data;
      blank_snap_d = bus.blank_mask;
      dp_snap_d    = bus.dp_mask;
      blink_snap_d = bus.blink_mask;
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_comb begin
    an_d = 8'hFF;
    if (!guard && !dark) an_d[idx_q] = 1'b0;
    dp_d = ~dp_snap_q[idx_q] | dark;
  end

  // Reset snapshot is all-blank with every digit masked, giving one dark frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q   <= '0;
      idx_q         <= '0;
      snap_q        <= 32'hFFFF_FFFF;
      blank_snap_q  <= 8'hFF;
      dp_snap_q     <= 8'h00;
      blink_snap_q  <= 8'h00;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      an_q          <= 8'hFF;
      seg_q         <= GLYPH_OFF;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      blank_snap_q  <= blank_snap_d;
      dp_snap_q     <= dp_snap_d;
      blink_snap_q  <= blink_snap_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      an_q          <= an_d;
      seg_q         <= glyph;
      dp_q          <= dp_d;
      frame_start_q <= wrap;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with a short scan period (8 clk/slot, 2 clk guard).
module tb_seg_scan;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_if bus ();

  seg_scan #(
    .SCAN_DIV     (8),
    .GUARD        (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;
  int wraps = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h3F, 7'h46, 7'h21, 7'h06, 7'h7F};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pos n = n-th falling edge after the one where frame_start was seen.
  task automatic goto(input int n);
    if (n > pos) repeat (n - pos) @(negedge clk);
    pos = n;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.frame_start && k < 200);
    chk("frame_start_seen", {31'd0, bus.frame_start}, 32'd1);
    pos = 0;
    wraps++;
  endtask

  // Called right after reset release on a falling edge.
  task automatic dark_frame(input string tag);
    int k;
    int bad;
    k   = 0;
    bad = 0;
    do begin
      @(negedge clk);
      k++;
      if (bus.an !== 8'hFF) bad++;
    end while (!bus.frame_start && k < 100);
    chk({tag, "_latency"}, k, 64);
    chk({tag, "_dark"}, bad, 0);
    pos   = 0;
    wraps = 1;
  endtask

  initial begin
    logic [7:0]  oh;
    logic [7:0]  exp_an;
    logic [31:0] d;
    int          bad;
    int          mism;
    int          s;
    logic        bon;

    bus.disp_data  = 32'h0;
    bus.blank_mask = 8'h00;
    bus.dp_mask    = 8'h00;
    bus.blink_mask = 8'h00;

    #1 reset = 1'b0;
    #1;
    chk("rst_an", bus.an, 8'hFF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp, 1'b1);
    chk("rst_fs", bus.frame_start, 1'b0);

    @(negedge clk);
    bus.disp_data = 32'h12B3_4B56;
    @(negedge clk);
    reset = 1'b1;
    dark_frame("first_frame");

    // Frame 2: snapshot 12B34B56
    goto(1);
    chk("fs_one_clk", bus.frame_start, 1'b0);
    chk("d0_guard_a", bus.an, 8'hFF);
    goto(2);
    chk("d0_guard_b", bus.an, 8'hFF);
    goto(3);
    chk("d0_first_an", bus.an, 8'hFE);
    chk("d0_first_seg", bus.seg, 7'h02);
    goto(8);
    chk("d0_last_an", bus.an, 8'hFE);
    chk("d0_last_seg", bus.seg, 7'h02);
    goto(9);
    chk("d1_guard", bus.an, 8'hFF);
    goto(44);
    chk("d5_an", bus.an, 8'hDF);
    chk("d5_dash", bus.seg, 7'h3F);
    goto(60);
    chk("d7_an", bus.an, 8'h7F);
    chk("d7_seg", bus.seg, 7'h79);

    // Frame 3: change data during digit 3 slot
    wait_frame();
    goto(28);
    chk("f3_d3_seg", bus.seg, 7'h19);
    bus.disp_data = 32'h9999_9999;
    goto(36);
    chk("f3_d4_old", bus.seg, 7'h30);
    goto(52);
    chk("f3_d6_old", bus.seg, 7'h24);
    goto(60);
    chk("f3_d7_old", bus.seg, 7'h79);

    // Frame 4: new data visible
    wait_frame();
    goto(4);
    chk("f4_d0_new", bus.seg, 7'h10);
    chk("f4_d0_an", bus.an, 8'hFE);
    goto(60);
    chk("f4_d7_new", bus.seg, 7'h10);
    bus.blank_mask = 8'h80;

    // Frame 5: digit 7 blanked
    wait_frame();
    bad  = 0;
    mism = 0;
    for (int n = 1; n < 64; n++) begin
      goto(n);
      if (bus.an === 8'h7F) bad++;
      if (n % 8 == 4) begin
        s  = n / 8;
        oh = 8'h01 << s;
        exp_an = (s == 7) ? 8'hFF : ~oh;
        if (bus.an !== exp_an) mism++;
      end
    end
    chk("blank_never_7f", bad, 0);
    chk("blank_slot_an", mism, 0);
    bus.blank_mask = 8'h00;
    bus.dp_mask    = 8'h24;
    bus.blink_mask = 8'h03;

    // Frames 6..9: decimal points and blink on digits 0/1
    for (int f = 0; f < 4; f++) begin
      wait_frame();
      bon = ((wraps / 2) % 2) == 0;
      for (int sl = 0; sl < 8; sl++) begin
        goto(sl * 8 + 4);
        oh = 8'h01 << sl;
        exp_an = (sl < 2 && !bon) ? 8'hFF : ~oh;
        chk($sformatf("blink_an_f%0d_s%0d", f, sl), bus.an, exp_an);
        chk($sformatf("dp_f%0d_s%0d", f, sl), bus.dp, (sl == 2 || sl == 5) ? 1'b0 : 1'b1);
      end
    end
    bus.dp_mask    = 8'h00;
    bus.blink_mask = 8'h00;
    bus.disp_data  = 32'hFFFF_FFF0;

    // Decode sweep on digit 0
    for (int c = 0; c < 16; c++) begin
      wait_frame();
      goto(4);
      chk($sformatf("decode_%0h", c), bus.seg, glyph_tab[c]);
      chk($sformatf("decode_an_%0h", c), bus.an, 8'hFE);
      d = 32'hFFFF_FFF0 | (c + 1);
      bus.disp_data = d;
    end

    // Asynchronous reset mid-slot
    wait_frame();
    goto(4);
    chk("pre_reset_an", bus.an, 8'hFE);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_an", bus.an, 8'hFF);
    chk("async_rst_seg", bus.seg, 7'h7F);
    chk("async_rst_dp", bus.dp, 1'b1);
    bus.disp_data = 32'h12B3_4B56;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    dark_frame("rerelease");
    goto(4);
    chk("restart_d0_an", bus.an, 8'hFE);
    chk("restart_d0_seg", bus.seg, 7'h02);
    goto(12);
    chk("restart_d1_an", bus.an, 8'hFD);
    chk("restart_d1_seg", bus.seg, 7'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
